xnor_descrambler: RTL and testbench

XNOR_DESCRAMBLER -- requirements
Module: xnor_descrambler

---
 rtl/xnor_scr_pkg.sv | 21 ++
 rtl/xnor_scr_tap.sv | 31 +++
 rtl/xnor_descrambler.sv | 104 ++++++++++
 tb/tb_xnor_descrambler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xnor_scr_pkg.sv
// Shared types and constants for the 1+x^6+x^7 XNOR descrambler.
// No logic of its own; no latency or backpressure.
// Tap positions are fixed by the polynomial, independent of SR_LEN.
package xnor_scr_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int TAP_A        = 5;
    localparam int TAP_B        = 6;
    localparam int DEF_SR_LEN   = 7;
    localparam int DEF_LOCK_RUN = 16;

    function automatic logic xnor3(input logic a, input logic b, input logic c);
        return ~(a ^ b ^ c);
    endfunction

endpackage

// File: rtl/xnor_scr_tap.sv
// Descrambler shift register of received scrambled bits plus XNOR tap.
// d is combinational from in_bit and the pre-shift register; shift on shift_en.
// No backpressure of its own; the caller gates shift_en with its handshake.
module xnor_scr_tap
    import xnor_scr_pkg::*;
#(
    parameter int SR_LEN = DEF_SR_LEN
) (
    input  logic clk,
    input  logic areset_n,
    input  logic shift_en,
    input  logic clr,
    input  logic in_bit,
    output logic d
);

    logic [SR_LEN-1:0] sr;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= {sr[SR_LEN-2:0], in_bit};
        end
    end

    assign d = xnor3(in_bit, sr[TAP_A], sr[TAP_B]);

endmodule

// File: rtl/xnor_descrambler.sv
// Serial self-synchronising XNOR descrambler with idle-pattern lock detection.
// Latency: accept to out_valid exactly 1 cycle through a one-entry output register.
// Backpressure: after fill, in_ready = ~out_valid | out_ready; sync_clr blocks input.
module xnor_descrambler
    import xnor_scr_pkg::*;
#(
    parameter int SR_LEN   = DEF_SR_LEN,
    parameter int LOCK_RUN = DEF_LOCK_RUN
) (
    input  logic clk,
    input  logic areset_n,
    input  logic in_bit,
    input  logic in_valid,
    output logic in_ready,
    input  logic sync_clr,
    output logic out_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic locked
);

    localparam int FW = $clog2(SR_LEN);
    localparam int RW = $clog2(LOCK_RUN + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(SR_LEN - 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'(LOCK_RUN - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(LOCK_RUN);

    state_t        state;
    logic [FW-1:0] fill_cnt;
    logic [RW-1:0] run_cnt;
    logic          d;
    logic          accept;
    logic          emit;

    // While filling nothing is emitted, so the output register never blocks input.
    assign in_ready = areset_n & ~sync_clr & ((state == FILL) | ~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign emit     = out_valid & out_ready;

    xnor_scr_tap #(
        .SR_LEN (SR_LEN)
    ) u_tap (
        .clk      (clk),
        .areset_n (areset_n),
        .shift_en (accept),
        .clr      (sync_clr),
        .in_bit   (in_bit),
        .d        (d)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= FILL;
            fill_cnt  <= '0;
            run_cnt   <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            locked    <= 1'b0;
        end else if (sync_clr) begin
            state     <= FILL;
            fill_cnt  <= '0;
            run_cnt   <= '0;
            out_valid <= 1'b0;
            locked    <= 1'b0;
        end else begin
            if (accept && state != FILL) begin
                out_bit   <= d;
                out_valid <= 1'b1;
            end else if (emit) begin
                out_valid <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (accept) begin
                        if (fill_cnt == FILL_LAST) begin
                            state <= HUNT;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                HUNT: begin
                    if (accept) begin
                        if (!d) begin
                            run_cnt <= '0;
                        end else if (run_cnt == RUN_LAST) begin
                            run_cnt <= RUN_MAX;
                            state   <= LOCKED;
                            locked  <= 1'b1;
                        end else if (run_cnt != RUN_MAX) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    // Data zeros never drop lock; only sync_clr or reset do.
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_xnor_descrambler.sv
// Randomised and directed bench for xnor_descrambler against a bit-history model.
// Model predicts in_ready/out_valid/out_bit/locked each cycle from accepted-bit history.
// Exercises backpressure, sync_clr, async reset and lock on scrambled idle ones.
module tb_xnor_descrambler;

    localparam int SR_LEN   = 7;
    localparam int LOCK_RUN = 16;

    logic clk = 1'b0;
    logic areset_n = 1'b0;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic sync_clr = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready;
    logic out_bit;
    logic out_valid;
    logic locked;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: history of accepted bits since last clear
    bit hist[$];
    int n_acc = 0;
    int run = 0;
    bit m_locked = 1'b0;
    bit m_ov = 1'b0;
    bit m_ob = 1'b0;
    bit m_acc = 1'b0;

    // Transmit-side XNOR scrambler history, bit 0 newest
    logic [6:0] scr = '0;
    bit exp_plain[$];
    bit dut_stream[$];

    xnor_descrambler #(
        .SR_LEN   (SR_LEN),
        .LOCK_RUN (LOCK_RUN)
    ) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sync_clr  (sync_clr),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    function automatic bit m_rdy();
        return areset_n && !sync_clr && (n_acc < SR_LEN || !m_ov || out_ready);
    endfunction

    function automatic logic scr_out(input logic p);
        return ~(p ^ scr[5] ^ scr[6]);
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        n_acc = 0;
        run = 0;
        m_locked = 1'b0;
        m_ov = 1'b0;
        m_ob = 1'b0;
    endtask

    // Applies one clock edge to the model using the inputs currently driven.
    task automatic model_update();
        bit acc, emit, dd;
        int sz;
        m_acc = 1'b0;
        if (!areset_n) return;
        if (sync_clr) begin
            model_reset();
            return;
        end
        acc = in_valid && m_rdy();
        emit = m_ov && out_ready;
        m_acc = acc;
        if (acc) begin
            if (n_acc >= SR_LEN) begin
                sz = hist.size();
                dd = ~(in_bit ^ hist[sz-6] ^ hist[sz-7]);
                m_ob = dd;
                m_ov = 1'b1;
                if (!m_locked) begin
                    run = dd ? run + 1 : 0;
                    if (run >= LOCK_RUN) m_locked = 1'b1;
                end
            end
            hist.push_back(in_bit);
            if (hist.size() > 16) void'(hist.pop_front());
            n_acc++;
        end else if (emit) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic xmit(input logic p, input bit track, input bit raw);
        bit done;
        done = 1'b0;
        in_bit = raw ? p : scr_out(p);
        in_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            step();
            if (m_acc) begin
                done = 1'b1;
                if (!raw) scr = {scr[5:0], in_bit};
                if (track) exp_plain.push_back(p);
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL xmit_timeout: got no accept expected accept at %0t", $time);
        end
    endtask

    task automatic do_sync();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("in_ready", in_ready, m_rdy());
        chk("out_valid", out_valid, m_ov);
        chk("locked", locked, m_locked);
        if (m_ov) chk("out_bit", out_bit, m_ob);
        if (!areset_n) chk("rst_out_bit", out_bit, 1'b0);
        if (areset_n && out_valid && out_ready) dut_stream.push_back(out_bit);
    end

    initial begin
        logic p, held;
        int n;
        bit pat[7];
        pat = '{1, 0, 1, 0, 1, 0, 1};

        // Reset values
        #2;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_bit", out_bit, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        areset_n = 1'b1;

        // Fill with 1010101, then a 1 descrambles to 1 one cycle later
        foreach (pat[i]) begin
            xmit(pat[i], 1'b0, 1'b1);
            @(negedge clk);
            chk("fill_no_out", out_valid, 1'b0);
        end
        xmit(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("first_out_valid", out_valid, 1'b1);
        chk("first_out_bit", out_bit, 1'b1);

        // Lock on scrambled ones, with a zero at run 15 restarting the count
        do_sync();
        dut_stream.delete();
        exp_plain.delete();
        for (int i = 0; i < SR_LEN; i++) xmit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) xmit(1'b1, 1'b1, 1'b0);
        xmit(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) xmit(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("no_lock_at_15", locked, 1'b0);
        xmit(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("lock_at_16", locked, 1'b1);

        // Five cycles of out_ready low with input offered
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        p = 1'($urandom_range(0, 1));
        held = p;
        in_bit = scr_out(p);
        in_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (m_acc) begin
                n++;
                scr = {scr[5:0], in_bit};
                exp_plain.push_back(p);
                held = p;
                p = 1'($urandom_range(0, 1));
                in_bit = scr_out(p);
            end
            @(negedge clk);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_bit", out_bit, held);
        end
        chk_int("hold_accepts", n, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) xmit(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        repeat (3) step();
        chk_int("stream_len", dut_stream.size(), exp_plain.size());
        foreach (exp_plain[i]) begin
            if (i < dut_stream.size()) chk("stream_bit", dut_stream[i], exp_plain[i]);
        end

        // sync_clr while locked with a bit pending and another offered
        xmit(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_clr_locked", locked, 1'b1);
        chk("pre_clr_valid", out_valid, 1'b1);
        in_valid = 1'b1;
        in_bit = 1'b1;
        do_sync();
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr_locked", locked, 1'b0);
        chk("clr_valid", out_valid, 1'b0);
        for (int i = 0; i < SR_LEN; i++) begin
            xmit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            @(negedge clk);
            chk("refill_no_out", out_valid, 1'b0);
        end
        xmit(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("refill_out", out_valid, 1'b1);
        chk("refill_bit", out_bit, 1'b1);

        // Randomised traffic, mostly scrambled idle ones
        for (int c = 0; c < 3000; c++) begin
            p = ($urandom_range(0, 15) != 0) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sync_clr = ($urandom_range(0, 199) == 0);
            in_bit = scr_out(p);
            step();
            if (m_acc) scr = {scr[5:0], in_bit};
        end
        in_valid = 1'b0;
        sync_clr = 1'b0;
        out_ready = 1'b1;

        // Asynchronous reset mid-hunt with an output pending
        do_sync();
        for (int i = 0; i < SR_LEN; i++) xmit(1'b1, 1'b0, 1'b0);
        xmit(1'b1, 1'b0, 1'b0);
        xmit(1'b0, 1'b0, 1'b0);
        xmit(1'b1, 1'b0, 1'b0);
        #2;
        chk("pre_arst_valid", out_valid, 1'b1);
        areset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_bit", out_bit, 1'b0);
        chk("arst_locked", locked, 1'b0);
        chk("arst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        for (int i = 0; i < SR_LEN; i++) begin
            xmit(1'b1, 1'b0, 1'b0);
            @(negedge clk);
            chk("post_arst_fill", out_valid, 1'b0);
        end
        for (int i = 0; i < LOCK_RUN + 2; i++) xmit(1'b1, 1'b0, 1'b0);
        repeat (3) step();
        chk("post_arst_lock", locked, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
